// File: rtl/taptempo_pkg.sv
// taptempo_pkg: constants and types shared across the tap-tempo blocks.
//   BPM_PER_MAX      largest period the period counter can report (time pulses)
//   BPM_MAX          saturation ceiling of the displayed BPM
//   PULSE_PER_NS_DEF default time-pulse period in ns
//   PER_W / BPM_W    period and BPM bus widths
//   DIVIDEND / DIV_W pulses-per-minute constant and its width at the default pulse period
//   state_t          per2bpm FSM states
package taptempo_pkg;

    localparam int unsigned BPM_PER_MAX      = 62_600;
    localparam int unsigned BPM_MAX          = 250;
    localparam int unsigned PULSE_PER_NS_DEF = 5120;

    localparam int unsigned PER_W = $clog2(BPM_PER_MAX + 1) + 1;
    localparam int unsigned BPM_W = $clog2(BPM_MAX + 1);

    localparam longint unsigned NS_PER_MIN = 64'd60_000_000_000;

    // Number of time pulses in one minute for a given pulse period.
    function automatic longint unsigned dividend_for(input int unsigned pulse_ns);
        return NS_PER_MIN / 64'(pulse_ns);
    endfunction

    localparam longint unsigned DIVIDEND = NS_PER_MIN / 64'(PULSE_PER_NS_DEF);
    localparam int unsigned     DIV_W    = $clog2(DIVIDEND + 1);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

endpackage

// File: rtl/seq_divu.sv
// seq_divu: unsigned restoring divider, one quotient bit per clock.
//   clk_i       system clock
//   rst_i       asynchronous active-high reset
//   start_i     load operands and (re)start; also restarts a division in flight
//   abort_i     drop the division in flight without producing done
//   dividend_i  DVD_W-bit dividend
//   divisor_i   DVS_W-bit divisor (0 yields an all-ones quotient)
//   quotient_o  quotient, valid while done_o is high
//   done_o      high for the one cycle after the last quotient bit is shifted in
module seq_divu #(
    parameter int unsigned DVD_W = 24,
    parameter int unsigned DVS_W = 17
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic [DVD_W-1:0] quotient_o,
    output logic             done_o
);

    localparam int unsigned STEP_W = $clog2(DVD_W + 1);

    logic [DVS_W:0]    rem_q;
    logic [DVD_W-1:0]  quo_q;
    logic [DVS_W-1:0]  dvs_q;
    logic [STEP_W-1:0] step_q;
    logic              active_q;

    logic [DVS_W:0] rem_sh;
    logic [DVS_W:0] rem_sub;
    logic           take;

    // The partial remainder is always below the divisor, so its top bit is
    // always free to receive the shift without overflow.
    always_comb begin
        rem_sh  = (DVS_W + 1)'({rem_q, quo_q[DVD_W-1]});
        rem_sub = rem_sh - {1'b0, dvs_q};
        take    = (rem_sh >= {1'b0, dvs_q});
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            step_q   <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            rem_q    <= '0;
            quo_q    <= dividend_i;
            dvs_q    <= divisor_i;
            step_q   <= STEP_W'(DVD_W);
            active_q <= 1'b1;
        end else if (abort_i) begin
            active_q <= 1'b0;
        end else if (active_q) begin
            if (step_q != '0) begin
                rem_q  <= take ? rem_sub : rem_sh;
                quo_q  <= {quo_q[DVD_W-2:0], take};
                step_q <= step_q - 1'b1;
            end else begin
                active_q <= 1'b0;
            end
        end
    end

    assign quotient_o = quo_q;
    assign done_o     = active_q && (step_q == '0);

endmodule

// File: rtl/per2bpm.sv
// per2bpm: converts a tap period (count of time pulses) into beats per minute,
// bpm = min(pulses_per_minute / period, BPM_MAX), via a sequential divider.
//   clk_i            system clock
//   rst_i            asynchronous active-high reset
//   btn_per_i        measured tap period in time pulses
//   btn_per_valid_i  one-cycle strobe qualifying btn_per_i; restarts any division in flight
//   bpm_o            last computed BPM, held between results
//   bpm_valid_o      one-cycle strobe when bpm_o updates
//   busy_o           high while a division is in progress
module per2bpm
    import taptempo_pkg::*;
#(
    parameter int unsigned PULSE_PER_NS = PULSE_PER_NS_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [PER_W-1:0] btn_per_i,
    input  logic             btn_per_valid_i,
    output logic [BPM_W-1:0] bpm_o,
    output logic             bpm_valid_o,
    output logic             busy_o
);

    localparam longint unsigned DVD   = dividend_for(PULSE_PER_NS);
    localparam int unsigned     DVD_W = $clog2(DVD + 1);

    state_t           state_q;
    logic [BPM_W-1:0] bpm_q;
    logic             bpm_valid_q;
    logic             busy_q;

    logic [DVD_W-1:0] quotient;
    logic             div_done;
    logic [BPM_W-1:0] bpm_sat;

    seq_divu #(
        .DVD_W(DVD_W),
        .DVS_W(PER_W)
    ) u_div (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (btn_per_valid_i),
        .abort_i   (1'b0),
        .dividend_i(DVD_W'(DVD)),
        .divisor_i (btn_per_i),
        .quotient_o(quotient),
        .done_o    (div_done)
    );

    always_comb begin
        if (quotient > DVD_W'(BPM_MAX)) begin
            bpm_sat = BPM_W'(BPM_MAX);
        end else begin
            bpm_sat = quotient[BPM_W-1:0];
        end
    end

    // A new valid in any state restarts the divider (latest period wins), so
    // DIV simply stays put and ignores a done from the superseded division.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            bpm_q       <= '0;
            bpm_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            bpm_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (btn_per_valid_i) begin
                        state_q <= DIV;
                        busy_q  <= 1'b1;
                    end
                end
                DIV: begin
                    if (!btn_per_valid_i && div_done) begin
                        state_q     <= DONE;
                        bpm_q       <= bpm_sat;
                        bpm_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (btn_per_valid_i) begin
                        state_q <= DIV;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bpm_o       = bpm_q;
    assign bpm_valid_o = bpm_valid_q;
    assign busy_o      = busy_q;

endmodule

// File: doc/per2bpm.md
# per2bpm

Converts the tap period measured by the period counter (count of 5.12 µs time pulses between two button rises) into beats per minute. It uses a multi-cycle restoring divider and saturates the result to BPM_MAX. It sits between the period counter (upstream, supplying period and a one-cycle valid) and the BPM display/averaging stage (downstream, consuming `bpm_o`/`bpm_valid_o`).

## Interface
- PULSE_PER_NS, 5120: time-pulse period in ns; sets the dividend.
- BPM_MAX, 250: saturation ceiling of the output BPM.
- BPM_PER_MAX, 62_600: largest period the counter can report.
- PER_W, $clog2(BPM_PER_MAX+1)+1 (=17): period input width.
- BPM_W, $clog2(BPM_MAX+1) (=8): output width.
- clk_i  input  1  system clock.
- rst_i  input  1  reset; asynchronous, active-high.
- btn_per_i  input  PER_W  measured tap period in time pulses.
- btn_per_valid_i  input  1  one-cycle strobe; `btn_per_i` is valid when high.
- bpm_o  output  BPM_W  last computed BPM; held between results.
- bpm_valid_o  output  1  one-cycle strobe when `bpm_o` updates.
- busy_o  output  1  high while a division is in progress.

## Operation
- Dividend constant: DIVIDEND = 60_000_000_000 / PULSE_PER_NS, which is 11_718_750 by default. Its width is DIV_W = $clog2(DIVIDEND+1) = 24.
- Result: bpm = floor(DIVIDEND / btn_per_i), clamped to BPM_MAX.
- Division is unsigned restoring division with one quotient bit per clock. Registers:
  - remainder: PER_W+1 bits.
  - quotient/dividend shift register: DIV_W bits.
  - divisor: PER_W bits.
  - step counter: $clog2(DIV_W+1) bits.
- FSM states:
  - IDLE: on `btn_per_valid_i`, latch the divisor, load the dividend, clear the remainder, set step = DIV_W, go to DIV.
  - DIV: each cycle, shift the dividend MSB into the remainder. If remainder ≥ divisor, subtract it and shift in quotient bit 1; otherwise shift in 0. Decrement step. When step reaches 0, go to DONE.
  - DONE: `bpm_o` ← min(quotient, BPM_MAX); `bpm_valid_o` = 1 for exactly this cycle; return to IDLE.
- Divisor 0 is not special-cased. Restoring division yields an all-ones quotient, which saturates to BPM_MAX.
- Period ≥ BPM_PER_MAX (counter saturated or timeout) is computed normally. At the default parameters it yields 187.
- `btn_per_valid_i` in DIV or DONE aborts the current division. The new period is latched and division restarts from step DIV_W (latest wins). The aborted result is never published.
- Reset (any time, including mid-division):
  - state = IDLE.
  - `bpm_o` = 0, `bpm_valid_o` = 0, `busy_o` = 0.
  - Internal registers cleared.
  - A division interrupted by reset produces no output.

## Timing
- `btn_per_valid_i` sampled high at clock edge N: `busy_o` = 1 from edge N to N+25.
- `bpm_valid_o` and the new `bpm_o` are visible after edge N+25; latency is 25 cycles (DIV_W + 1).
- `busy_o` is 1 in DIV and DONE and 0 in IDLE. It drops after edge N+26.
- `bpm_valid_o` is never high for two consecutive cycles.
- Back-to-back valids are legal. The second restarts the computation, and only one `bpm_valid_o` pulse follows, 25 cycles after the last valid.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `taptempo_pkg`:
  - BPM_PER_MAX (replaces the global define).
  - BPM_MAX.
  - PULSE_PER_NS default.
  - DIVIDEND and DIV_W as derived localparams.
  - FSM state enum {IDLE, DIV, DONE}.
- One sub-module is natural: `seq_divu` (generic unsigned sequential divider with start/abort/done and parameterised widths). `per2bpm` holds only the FSM glue and saturation.

## Test plan
- `btn_per_i`=46_875 with valid pulse -> `bpm_o`=250, `bpm_valid_o` high exactly 25 cycles later for 1 cycle.
- `btn_per_i`=50_000 -> `bpm_o`=234; `btn_per_i`=62_600 -> `bpm_o`=187.
- `btn_per_i`=1 -> 250 (saturated); `btn_per_i`=0 -> 250 with no hang, `busy_o` low after 26 cycles.
- Valid with 50_000, then valid with 46_875 ten cycles later -> a single `bpm_valid_o`, 25 cycles after the second valid, `bpm_o`=250.
- Assert `rst_i` at step 12 of a division -> `bpm_o`=0, `busy_o`=0, and no `bpm_valid_o` pulse afterwards until a new valid arrives.
- Random periods 0..BPM_PER_MAX against the model min(11_718_750/p, 250) -> exact match, one valid per request.
